// File: rtl/multiplicador_secuencial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multiplicador_secuencial_pkg
//  Description : Shared definitions for the sequential fixed-point multiplier
//                and the saturating adder stage: default operand width and
//                fractional bits, saturation limits, FSM state encoding and
//                a two's-complement magnitude helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package multiplicador_secuencial_pkg;

    // Default operand/result width and fractional bits (Q8.10)
    localparam int unsigned MUL_W = 19;
    localparam int unsigned MUL_F = 10;

    // Width of the shift-add bit counter
    localparam int unsigned CNT_W = $clog2(MUL_W);

    // Saturation limits, also used by the downstream adder stage
    localparam logic [MUL_W-1:0] SAT_MAX = {1'b0, {(MUL_W-1){1'b1}}};
    localparam logic [MUL_W-1:0] SAT_MIN = {1'b1, {(MUL_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Magnitude as an unsigned W-bit value; the most negative code maps to
    // itself, which is exactly 2^(W-1) when read as unsigned.
    function automatic logic [MUL_W-1:0] abs_w(input logic [MUL_W-1:0] x);
        return x[MUL_W-1] ? -x : x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multiplicador_secuencial_if.sv
`default_nettype none
// ============================================================================
//  Module      : multiplicador_secuencial_if
//  Description : Request/result bundle of the sequential multiplier.
//                Start, A, B      : request side (master drives)
//                Busy, Done, Pout : status/result side (slave drives)
//  Revision    : 1.0 - initial release
// ============================================================================
interface multiplicador_secuencial_if;
    import multiplicador_secuencial_pkg::*;

    logic             Start;
    logic [MUL_W-1:0] A;
    logic [MUL_W-1:0] B;
    logic             Busy;
    logic             Done;
    logic [MUL_W-1:0] Pout;

    modport master (
        output Start, A, B,
        input  Busy, Done, Pout
    );

    modport slave (
        input  Start, A, B,
        output Busy, Done, Pout
    );

endinterface
`default_nettype wire

// File: rtl/multiplicador_secuencial_saturador_q.sv
`default_nettype none
// ============================================================================
//  Module      : saturador_q
//  Description : Combinational rescale-and-saturate. Shifts a 2W-bit product
//                magnitude right by F (truncation toward zero, since it acts
//                on the magnitude), clamps to the signed W-bit range and
//                applies the sign.
//  Ports       : mag_i  [2W-1:0] unsigned product magnitude
//                sign_i          result sign (1 = negative)
//                res_o  [W-1:0]  saturated two's-complement result
//  Revision    : 1.0 - initial release
// ============================================================================
module saturador_q
    import multiplicador_secuencial_pkg::*;
(
    input  wire logic [2*MUL_W-1:0] mag_i,
    input  wire logic               sign_i,
    output logic      [MUL_W-1:0]   res_o
);

    // Magnitude limits expressed at full accumulator width
    localparam logic [2*MUL_W-1:0] c_POS_LIM = {{MUL_W{1'b0}}, SAT_MAX};
    localparam logic [2*MUL_W-1:0] c_NEG_LIM = {{MUL_W{1'b0}}, SAT_MIN};

    logic [2*MUL_W-1:0] w_m;

    assign w_m = mag_i >> MUL_F;

    always_comb begin
        res_o = w_m[MUL_W-1:0];
        if (sign_i) begin
            // A magnitude of exactly 2^(W-1) is representable when negative
            if (w_m > c_NEG_LIM) begin
                res_o = SAT_MIN;
            end else begin
                res_o = -w_m[MUL_W-1:0];
            end
        end else if (w_m > c_POS_LIM) begin
            res_o = SAT_MAX;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multiplicador_secuencial.sv
`default_nettype none
// ============================================================================
//  Module      : multiplicador_secuencial
//  Description : Sequential signed fixed-point multiplier. Radix-2 shift-add
//                over operand magnitudes, one multiplier bit per clock, then
//                rescale/saturate and register the result. Latency W+1
//                cycles from the Start edge to Done.
//  Ports       : Clk    rising-edge clock
//                Reset  synchronous, active-high
//                bus    slave side of multiplicador_secuencial_if
//                       (Start/A/B in, Busy/Done/Pout out)
//  Revision    : 1.0 - initial release
// ============================================================================
module multiplicador_secuencial
    import multiplicador_secuencial_pkg::*;
(
    input  wire logic                 Clk,
    input  wire logic                 Reset,
    multiplicador_secuencial_if.slave bus
);

    state_t             r_state_q;
    logic [CNT_W-1:0]   r_i_q;
    logic [2*MUL_W-1:0] r_p_q;
    logic [MUL_W-1:0]   r_a_q;
    logic [MUL_W-1:0]   r_b_q;
    logic               r_s_q;
    logic               r_busy_q;
    logic               r_done_q;
    logic [MUL_W-1:0]   r_pout_q;

    logic [2*MUL_W-1:0] w_a_ext;
    logic [2*MUL_W-1:0] w_p_d;
    logic [MUL_W-1:0]   w_sat;

    // Partial product for the current multiplier bit
    assign w_a_ext = {{MUL_W{1'b0}}, r_a_q};
    assign w_p_d   = r_b_q[r_i_q] ? (r_p_q + (w_a_ext << r_i_q)) : r_p_q;

    saturador_q u_saturador_q (
        .mag_i  (r_p_q),
        .sign_i (r_s_q),
        .res_o  (w_sat)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state_q <= IDLE;
            r_i_q     <= '0;
            r_p_q     <= '0;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_s_q     <= 1'b0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
            r_pout_q  <= '0;
        end else begin
            r_done_q <= 1'b0;
            unique case (r_state_q)
                IDLE: begin
                    if (bus.Start) begin
                        r_s_q     <= bus.A[MUL_W-1] ^ bus.B[MUL_W-1];
                        r_a_q     <= abs_w(bus.A);
                        r_b_q     <= abs_w(bus.B);
                        r_p_q     <= '0;
                        r_i_q     <= '0;
                        r_busy_q  <= 1'b1;
                        r_state_q <= MULT;
                    end
                end
                MULT: begin
                    r_p_q <= w_p_d;
                    r_i_q <= r_i_q + 1'b1;
                    if (r_i_q == CNT_W'(MUL_W - 1)) begin
                        r_state_q <= FIN;
                    end
                end
                FIN: begin
                    r_pout_q  <= w_sat;
                    r_done_q  <= 1'b1;
                    r_busy_q  <= 1'b0;
                    r_state_q <= IDLE;
                end
                default: begin
                    r_busy_q  <= 1'b0;
                    r_state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.Busy = r_busy_q;
    assign bus.Done = r_done_q;
    assign bus.Pout = r_pout_q;

endmodule
`default_nettype wire

// File: tb/tb_multiplicador_secuencial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multiplicador_secuencial
//  Description : Directed self-checking bench for multiplicador_secuencial.
//                Hand-computed Q8.10 products, latency/Busy timing, Start
//                while busy, back-to-back Start, and Reset mid-operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplicador_secuencial;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    multiplicador_secuencial_if bus_if ();

    multiplicador_secuencial u_dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One operation: Start pulse, wait for Done (bounded), check latency,
    // Busy duration and result. glitch_at>0 re-asserts Start with other
    // operands at that cycle. done_now checks the Start lands in a Done cycle.
    task automatic run_op(input string tag, input logic [18:0] a, input logic [18:0] b,
                          input logic [18:0] exp, input int glitch_at, input bit done_now);
        int cnt;
        int busy_cnt;
        bit seen;
        @(negedge clk);
        if (done_now) check({tag, "_start_in_done"}, {31'd0, bus_if.Done}, 32'd1);
        bus_if.Start = 1'b1;
        bus_if.A     = a;
        bus_if.B     = b;
        @(posedge clk); #1;
        check({tag, "_busy_after_start"}, {31'd0, bus_if.Busy}, 32'd1);
        bus_if.Start = 1'b0;
        bus_if.A     = 19'($urandom);
        bus_if.B     = 19'($urandom);
        cnt      = 0;
        busy_cnt = 1;
        seen     = 1'b0;
        while (!seen && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
            if (bus_if.Done) seen = 1'b1;
            else if (bus_if.Busy) busy_cnt++;
            if (cnt == glitch_at) begin
                bus_if.Start = 1'b1;
                bus_if.A     = 19'h3FFFF;
                bus_if.B     = 19'h3FFFF;
            end else begin
                bus_if.Start = 1'b0;
            end
        end
        bus_if.Start = 1'b0;
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_latency"}, cnt, 32'd20);
        check({tag, "_busy_cycles"}, busy_cnt, 32'd20);
        check({tag, "_busy_at_done"}, {31'd0, bus_if.Busy}, 32'd0);
        check({tag, "_pout"}, {13'd0, bus_if.Pout}, {13'd0, exp});
    endtask

    initial begin
        int done_cnt;
        n_assert     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus_if.Start = 1'b0;
        bus_if.A     = '0;
        bus_if.B     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, bus_if.Busy}, 32'd0);
        check("reset_done", {31'd0, bus_if.Done}, 32'd0);
        check("reset_pout", {13'd0, bus_if.Pout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 3.0 * 2.0 = 6.0
        run_op("mul_3x2", 19'h00C00, 19'h00800, 19'h01800, -1, 1'b0);
        // Start while busy ignored; first result unaffected
        run_op("glitch", 19'h00C00, 19'h00800, 19'h01800, 5, 1'b0);
        // Start in the Done cycle: -1.5 * 2.0 = -3.0
        run_op("b2b_neg", 19'h7FA00, 19'h00800, 19'h7F400, -1, 1'b1);

        // Done is a single pulse; Pout holds afterwards
        @(posedge clk); #1;
        check("done_pulse_width", {31'd0, bus_if.Done}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("pout_hold", {13'd0, bus_if.Pout}, 32'h7F400);

        run_op("sat_pos", 19'h3FFFF, 19'h3FFFF, 19'h3FFFF, -1, 1'b0);
        run_op("sat_neg", 19'h40000, 19'h00800, 19'h40000, -1, 1'b0);
        run_op("min_x_min", 19'h40000, 19'h40000, 19'h3FFFF, -1, 1'b0);
        run_op("trunc_pos", 19'h00001, 19'h00001, 19'h00000, -1, 1'b0);
        run_op("trunc_neg", 19'h7FFFF, 19'h00001, 19'h00000, -1, 1'b0);
        run_op("one_x_m1", 19'h00400, 19'h7FC00, 19'h7FC00, -1, 1'b0);
        run_op("exact_min", 19'h40000, 19'h00400, 19'h40000, -1, 1'b0);
        run_op("max_x_one", 19'h3FFFF, 19'h00400, 19'h3FFFF, -1, 1'b0);

        // Reset during MULT discards the operation
        @(negedge clk);
        bus_if.Start = 1'b1;
        bus_if.A     = 19'h00C00;
        bus_if.B     = 19'h00800;
        @(posedge clk);
        @(negedge clk);
        bus_if.Start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midreset_busy", {31'd0, bus_if.Busy}, 32'd0);
        check("midreset_done", {31'd0, bus_if.Done}, 32'd0);
        check("midreset_pout", {13'd0, bus_if.Pout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (bus_if.Done) done_cnt++;
        end
        check("midreset_no_done", done_cnt, 32'd0);

        // Reset and Start together: Reset wins
        @(negedge clk);
        rst          = 1'b1;
        bus_if.Start = 1'b1;
        bus_if.A     = 19'h00C00;
        bus_if.B     = 19'h00800;
        @(posedge clk); #1;
        check("rst_and_start_busy", {31'd0, bus_if.Busy}, 32'd0);
        @(negedge clk);
        rst          = 1'b0;
        bus_if.Start = 1'b0;

        run_op("after_reset", 19'h00C00, 19'h00800, 19'h01800, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multiplicador_secuencial.md
# multiplicador_secuencial

Sequential signed fixed-point multiplier that feeds the saturating adder stage of the filter datapath. It accepts two W-bit two's-complement operands in Q-format with F fractional bits and computes the product with a radix-2 shift-add loop, one bit per clock. It then rescales the product, truncating toward zero, saturates to W bits, and holds the result at a registered output until the next operation completes.

## Interface
- W, 19, operand and result width, two's complement.
- F, 10, fractional bits of operands and result.

- Clk input 1: rising-edge clock.
- Reset input 1: Reset, synchronous, active-high.
- Start input 1: request; sampled only in IDLE.
- A input W: signed multiplicand.
- B input W: signed multiplier.
- Busy output 1: high in MULT and FIN.
- Done output 1: one-cycle pulse when Pout updates.
- Pout output W: saturated signed product; held between operations.

## Operation
- States:
  - IDLE: Start=1 at an edge captures the sign S=A[W-1]^B[W-1], |A| and |B| as W-bit unsigned values (|0x40000|=0x40000), and a 2W-bit accumulator P=0. Counter i=0. Next state MULT.
  - MULT: each edge adds |A|<<i to P if bit i of |B| is 1, then increments i. After the edge processing i=W-1, next state FIN.
  - FIN: M=P>>F, unsigned.
    - If S=0 and M>2^(W-1)-1, Pout=19'h3FFFF.
    - If S=1 and M>2^(W-1), Pout=19'h40000.
    - Otherwise Pout = S ? -M : M, taken as the low W bits.
    - Done=1 for this edge only. Next state IDLE.
- Truncation is applied to the magnitude, so rounding is toward zero. A zero magnitude gives Pout=0 regardless of S.
- Saturation limits match the downstream adder: +max 0x3FFFF, -max 0x40000.
- Start while Busy=1 is ignored, with no queuing. A and B are don't-care after the capture edge.
- Reset, at any state including mid-MULT: state IDLE, Pout=0, Done=0, Busy=0, P=0, i=0. Any operation in progress is discarded.
- Reset and Start asserted together: Reset wins.

## Timing
- Start is accepted at edge k. MULT occupies edges k+1 through k+W. FIN registers Pout and Done at edge k+W+1, giving a latency of W+1 = 20 cycles.
- Busy is high from after edge k until after edge k+W+1.
- Start sampled at the edge that ends the Done cycle is accepted, which gives back-to-back throughput of one result per W+2 cycles.
- Pout changes only at the FIN edge or on Reset.
- Done is registered and glitch-free. The downstream stage samples Pout on Done.

## Structure
- Shared package holds:
  - the defaults W and F;
  - SAT_MAX = 2^(W-1)-1 and SAT_MIN = -2^(W-1);
  - the state encoding enum IDLE/MULT/FIN, 2 bits.
- The adder stage uses the same saturation constants from this package.
- One sub-module, `saturador_q`, is combinational. It takes a 2W-bit magnitude and the sign S, and produces the rescaled, saturated W-bit result. The FSM, counter and shift-add datapath stay in the top module.

## Test plan
- A=0x00C00 (3.0), B=0x00800 (2.0), Start pulse -> Done exactly 20 cycles later, Pout=0x01800 (6.0), Busy high for 20 cycles.
- A=0x7FA00 (-1.5), B=0x00800 -> Pout=0x7F400 (-3.0).
- A=0x3FFFF, B=0x3FFFF -> Pout=0x3FFFF. A=0x40000, B=0x00800 -> 0x40000. A=0x40000, B=0x40000 -> 0x3FFFF.
- Truncation: A=0x00001, B=0x00001 -> Pout=0. A=0x7FFFF (-1 LSB), B=0x00001 -> Pout=0x00000.
- Start re-asserted during MULT with different operands -> ignored; the first result is correct. Start in the Done cycle -> a second Done arrives 20 cycles later with the new result.
- Reset asserted at cycle 7 of MULT -> next edge gives Busy=0, Done=0, Pout=0, and no Done follows. A fresh Start then produces a correct result.
